ni_fifo_wr_arbiter: RTL and testbench

Packet-level round-robin write arbiter that shares one `gp_fifo` between `NUM_REQ` local producers in the network interface. It grants the FIFO write port to one requester at a time. The grant is held from the head flit to the flagged tail flit, so packets never interleave in the FIFO. It never writes into a full FIFO, so the FIFO `error` output cannot be caused by overflow.

---
 rtl/ni_arb_pkg.sv | 18 +
 rtl/ni_fifo_wr_arbiter_rr_picker.sv | 34 +++
 rtl/ni_fifo_wr_arbiter.sv | 93 +++++++++
 tb/tb_ni_fifo_wr_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ni_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ni_arb_pkg
// Description : Shared types and default sizes for the NI FIFO write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ni_arb_pkg;

    localparam int C_NUM_REQ = 4;
    localparam int C_DEPTH   = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage : ni_arb_pkg
`default_nettype wire

// File: rtl/ni_fifo_wr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational rotating-priority picker; the first set request
//               at or above base (wrapping) wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic [IDX_W-1:0] w_idx;

    // Scan from farthest to nearest so the nearest set bit is the last write.
    always_comb begin
        winner = '0;
        w_idx  = '0;
        any    = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = base + IDX_W'(k);
            if (req[w_idx]) begin
                winner = w_idx;
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/ni_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ni_fifo_wr_arbiter
// Description : Packet-level round-robin write arbiter sharing one gp_fifo
//               among NUM_REQ producers; grant held from head to tail flit.
// Revision    : 1.0 - initial release
// ============================================================================
module ni_fifo_wr_arbiter
    import ni_arb_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ,
    parameter int DEPTH   = C_DEPTH,
    parameter int IDX_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*DEPTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_write_en,
    output logic [DEPTH-1:0]         fifo_data_in,
    output logic                     busy,
    output logic [IDX_W-1:0]         owner
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_winner;
    logic             w_any;
    logic             w_write;
    logic             w_tail;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req_valid),
        .base   (r_rr_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    // Reset gates the write so a lock dropped by reset never leaks a flit.
    assign w_write = (r_state == LOCKED) & req_valid[r_owner] & ~fifo_full & ~reset;
    assign w_tail  = w_write & req_last[r_owner];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_any) begin
                r_owner <= w_winner;
            end
            if (w_tail) begin
                r_rr_ptr <= r_owner + IDX_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)  w_state_nxt = LOCKED;
            LOCKED:  if (w_tail) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = '0;
        fifo_write_en = 1'b0;
        fifo_data_in  = '0;
        busy          = (r_state == LOCKED);
        if ((r_state == LOCKED) && !reset) begin
            req_ready[r_owner] = ~fifo_full;
            fifo_write_en      = w_write;
            if (w_write) begin
                fifo_data_in = req_data[r_owner*DEPTH +: DEPTH];
            end
        end
    end

    assign owner = r_owner;

endmodule : ni_fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_ni_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ni_fifo_wr_arbiter
// Description : Directed self-checking bench for ni_fifo_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ni_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] sl [4];
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_write_en;
    logic [31:0] fifo_data_in;
    logic        busy;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt [4];
    int exp_own [5] = '{0, 1, 2, 3, 0};

    assign req_data = {sl[3], sl[2], sl[1], sl[0]};

    always #5 clk = ~clk;

    ni_fifo_wr_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_full     (fifo_full),
        .fifo_write_en (fifo_write_en),
        .fifo_data_in  (fifo_data_in),
        .busy          (busy),
        .owner         (owner)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_wen"}, 32'(fifo_write_en), 32'd0);
        check({tag, "_data"}, fifo_data_in, 32'd0);
    endtask

    task automatic wr(input string tag, input int own, input logic [31:0] d);
        check({tag, "_owner"}, 32'(owner), 32'(own));
        check({tag, "_wen"}, 32'(fifo_write_en), 32'd1);
        check({tag, "_ready"}, 32'(req_ready), 32'd1 << own);
        check({tag, "_data"}, fifo_data_in, d);
    endtask

    task automatic drive_all();
        for (int i = 0; i < 4; i++) begin
            sl[i]       = 32'h0A000000 | (32'(i) << 16) | 32'(cnt[i]);
            req_last[i] = cnt[i][0];
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin sl[i] = '0; cnt[i] = 0; end
        next(); next();
        mid();
        quiet("rst");
        next();

        // Idle after reset
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            mid();
            quiet("idle");
            next();
        end
        check("idle_owner", 32'(owner), 32'd0);
        check("idle_rr", 32'(dut.r_rr_ptr), 32'd0);

        // Requester 2, three-flit packet
        req_valid = 4'b0100; sl[2] = 32'h0101A5A5;
        mid();
        quiet("r2_req");
        next();
        mid();
        check("r2_busy", 32'(busy), 32'd1);
        wr("r2_f0", 2, 32'h0101A5A5);
        next();
        sl[2] = 32'h0000BBBB;
        mid();
        wr("r2_f1", 2, 32'h0000BBBB);
        next();
        sl[2] = 32'h00010001; req_last = 4'b0100;
        mid();
        wr("r2_f2", 2, 32'h00010001);
        next();
        req_valid = '0; req_last = '0;
        mid();
        quiet("r2_done");
        check("r2_rr", 32'(dut.r_rr_ptr), 32'd3);
        next();

        // All requesters, two-flit packets, fresh round-robin pointer
        reset = 1'b1;
        next();
        reset = 1'b0; req_valid = 4'b1111;
        drive_all();
        for (int p = 0; p < 5; p++) begin
            mid();
            check("rr_gap_busy", 32'(busy), 32'd0);
            check("rr_gap_wen", 32'(fifo_write_en), 32'd0);
            next();
            for (int f = 0; f < 2; f++) begin
                mid();
                wr("rr_pkt", exp_own[p], 32'h0A000000 | (32'(exp_own[p]) << 16) | 32'(cnt[exp_own[p]]));
                next();
                cnt[exp_own[p]]++;
                drive_all();
            end
        end
        req_valid = '0; req_last = '0;
        mid();
        check("rr_end_rr", 32'(dut.r_rr_ptr), 32'd1);
        next();

        // Owner 1 stalled by a full FIFO, requester 3 waiting
        req_valid = 4'b1010; req_last = 4'b1000;
        sl[1] = 32'h0100AAAA; sl[3] = 32'h03003333;
        next();
        mid();
        wr("full_f0", 1, 32'h0100AAAA);
        next();
        sl[1] = 32'h0100CCCC; fifo_full = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mid();
            check("full_ready", 32'(req_ready), 32'd0);
            check("full_wen", 32'(fifo_write_en), 32'd0);
            check("full_owner", 32'(owner), 32'd1);
            next();
        end
        fifo_full = 1'b0;
        mid();
        wr("full_resume", 1, 32'h0100CCCC);
        next();
        sl[1] = 32'h0100DDDD; req_last = 4'b1010;
        mid();
        wr("full_tail", 1, 32'h0100DDDD);
        next();
        req_valid = 4'b1000;
        mid();
        check("full_gap", 32'(busy), 32'd0);
        next();
        mid();
        wr("full_r3", 3, 32'h03003333);
        next();
        req_valid = '0; req_last = '0;

        // Owner 0 drops valid mid-packet while requester 1 waits
        req_valid = 4'b0011; req_last = 4'b0010;
        sl[0] = 32'h00000E01; sl[1] = 32'h01000F01;
        next();
        mid();
        wr("drop_f0", 0, 32'h00000E01);
        next();
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            mid();
            check("drop_owner", 32'(owner), 32'd0);
            check("drop_busy", 32'(busy), 32'd1);
            check("drop_wen", 32'(fifo_write_en), 32'd0);
            check("drop_ready", 32'(req_ready), 32'd1);
            next();
        end
        req_valid = 4'b0011; req_last = 4'b0011; sl[0] = 32'h00000E02;
        mid();
        wr("drop_tail", 0, 32'h00000E02);
        next();
        req_valid = 4'b0010;
        mid();
        check("drop_gap", 32'(busy), 32'd0);
        next();
        mid();
        wr("drop_r1", 1, 32'h01000F01);
        next();
        req_valid = '0; req_last = '0;

        // Reset while locked on owner 3
        req_valid = 4'b1000; sl[3] = 32'h03004444;
        next();
        mid();
        wr("rl_lock", 3, 32'h03004444);
        next();
        reset = 1'b1;
        mid();
        check("rl_rst_wen", 32'(fifo_write_en), 32'd0);
        check("rl_rst_ready", 32'(req_ready), 32'd0);
        next();
        reset = 1'b0; req_valid = 4'b1010;
        mid();
        check("rl_state", 32'(dut.r_state), 32'd0);
        check("rl_busy", 32'(busy), 32'd0);
        check("rl_owner", 32'(owner), 32'd0);
        check("rl_rr", 32'(dut.r_rr_ptr), 32'd0);
        next();
        mid();
        check("rl_win_owner", 32'(owner), 32'd1);
        check("rl_win_busy", 32'(busy), 32'd1);
        next();
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ni_fifo_wr_arbiter
`default_nettype wire
